// File: rtl/nap_alarm_trigger_if.sv
// ============================================================================
// Module      : nap_alarm_trigger_if
// Description : Bus bundle between the setting block / clock source and the
//               alarm trigger, with the buzzer-side status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nap_alarm_trigger_if;
  logic        en;
  logic        load;
  logic [23:0] target_time;
  logic [23:0] cur_time;
  logic        sec_tick;
  logic        stop;
  logic        snooze;
  logic        alarm;
  logic        armed;
  logic        missed;
  logic [23:0] target_out;
  logic [1:0]  state_out;

  modport master (
    output en, load, target_time, cur_time, sec_tick, stop, snooze,
    input  alarm, armed, missed, target_out, state_out
  );

  modport slave (
    input  en, load, target_time, cur_time, sec_tick, stop, snooze,
    output alarm, armed, missed, target_out, state_out
  );
endinterface

`default_nettype wire

// File: rtl/nap_alarm_trigger.sv
// ============================================================================
// Module      : nap_alarm_trigger
// Description : Latches a BCD wake time, compares it with the running clock on
//               each second tick and rings until stopped or timed out.
//               Optional snooze re-arm is enabled by defining ALARM_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nap_alarm_trigger #(
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_MIN = 5
) (
  input wire logic          clock,
  input wire logic          reset,
  nap_alarm_trigger_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2
  } state_t;

  localparam logic [5:0] c_ring_last = 6'(RING_SEC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_target;
  logic [23:0] w_target_nxt;
  logic [5:0]  r_ring_cnt;
  logic [5:0]  w_ring_cnt_nxt;
  logic        r_missed;
  logic        w_missed_nxt;
  logic        r_alarm;
  logic        r_armed;
  logic [23:0] w_snooze_target;
  logic        w_snooze_req;

`ifdef ALARM_SNOOZE_EN
  function automatic logic [7:0] bcd2bin(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 8'd10);
    ones = 4'(v % 8'd10);
    return {tens, ones};
  endfunction

  logic [7:0] w_min_sum;
  logic [7:0] w_hr_sum;

  // Minutes roll at 60 into hours, hours wrap at 24; seconds pass through.
  always_comb begin
    w_min_sum = bcd2bin(bus.cur_time[15:8]) + 8'(SNOOZE_MIN);
    w_hr_sum  = bcd2bin(bus.cur_time[23:16]);
    if (w_min_sum >= 8'd60) begin
      w_min_sum = w_min_sum - 8'd60;
      w_hr_sum  = w_hr_sum + 8'd1;
    end
    if (w_hr_sum >= 8'd24) begin
      w_hr_sum = w_hr_sum - 8'd24;
    end
    w_snooze_target = {bin2bcd(w_hr_sum), bin2bcd(w_min_sum), bus.cur_time[7:0]};
  end

  assign w_snooze_req = bus.snooze;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = bus.snooze;
  assign w_snooze_target = 24'h000000;
  assign w_snooze_req    = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_ring_cnt_nxt = r_ring_cnt;
    w_missed_nxt   = r_missed;

    if (bus.load) begin
      w_target_nxt   = bus.target_time;
      w_state_nxt    = ARMED;
      w_missed_nxt   = 1'b0;
      w_ring_cnt_nxt = 6'd0;
    end else begin
      case (r_state)
        IDLE: ;
        ARMED: begin
          if (bus.sec_tick && (bus.cur_time == r_target)) begin
            w_state_nxt    = RINGING;
            w_ring_cnt_nxt = 6'd0;
          end
        end
        RINGING: begin
          if (bus.stop) begin
            w_state_nxt = IDLE;
          end else if (w_snooze_req) begin
            w_state_nxt  = ARMED;
            w_target_nxt = w_snooze_target;
          end else if (bus.sec_tick) begin
            if (r_ring_cnt == c_ring_last) begin
              w_state_nxt  = IDLE;
              w_missed_nxt = 1'b1;
            end else begin
              w_ring_cnt_nxt = r_ring_cnt + 6'd1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_target   <= 24'h000000;
      r_ring_cnt <= 6'd0;
      r_missed   <= 1'b0;
      r_alarm    <= 1'b0;
      r_armed    <= 1'b0;
    end else if (bus.en) begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_missed   <= w_missed_nxt;
      r_alarm    <= (w_state_nxt == RINGING);
      r_armed    <= (w_state_nxt == ARMED);
    end
  end

  assign bus.alarm      = r_alarm;
  assign bus.armed      = r_armed;
  assign bus.missed     = r_missed;
  assign bus.target_out = r_target;
  assign bus.state_out  = r_state;

endmodule

`default_nettype wire
